multi_cycle_seq: RTL and testbench

MULTI_CYCLE_SEQ -- requirements
Module: multi_cycle_seq

---
 rtl/cpu_seq_pkg.sv | 56 +++++
 rtl/multi_cycle_seq_if.sv | 31 +++
 rtl/wait_timer.sv | 29 ++
 rtl/multi_cycle_seq.sv | 114 +++++++++++
 tb/tb_multi_cycle_seq.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared constants, opcode table and state encodings for the multi-cycle sequencer.
// Pure definitions; no latency or flow control of its own.
package cpu_seq_pkg;

  // Constants
  localparam int OPC_W   = 7;
  localparam int STATE_W = 3;
  localparam int WAIT_W  = 4;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] S_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] S_EXECUTE   = 3'd3;
  localparam logic [STATE_W-1:0] S_MEMORY    = 3'd4;
  localparam logic [STATE_W-1:0] S_WRITEBACK = 3'd5;
  localparam logic [STATE_W-1:0] S_TRAP      = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } op_class_e;

  function automatic op_class_e classify(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: return CLS_ALU;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_seq_if.sv
// Bundle of sequencer inputs (load status, memory word, branch target) and its outputs.
// master is the environment side, slave is the sequencer side.
interface multi_cycle_seq_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              UartOver;
  logic [DATA_W-1:0] MemInstr;
  logic [DATA_W-1:0] NextPc;
  logic [DATA_W-1:0] PcOut;
  logic [DATA_W-1:0] InstrOut;
  logic              MemReadEn;
  logic              MemWriteEn;
  logic              RegWriteEn;
  logic [2:0]        State;
  logic              IllegalInstr;
  logic [CNT_W-1:0]  CycleCnt;
  logic [CNT_W-1:0]  RetireCnt;

  modport master (
    output UartOver, MemInstr, NextPc,
    input  PcOut, InstrOut, MemReadEn, MemWriteEn, RegWriteEn,
           State, IllegalInstr, CycleCnt, RetireCnt
  );

  modport slave (
    input  UartOver, MemInstr, NextPc,
    output PcOut, InstrOut, MemReadEn, MemWriteEn, RegWriteEn,
           State, IllegalInstr, CycleCnt, RetireCnt
  );
endinterface

// File: rtl/wait_timer.sv
// Memory wait-state timer: load MEM_LAT, count down, done high on the last wait cycle.
// done is registered-state decode, 0 extra latency; no backpressure.
module wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = WAIT_W'(MEM_LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == WAIT_W'(1));
endmodule

// File: rtl/multi_cycle_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with wait states.
// Latency per instruction is MEM_LAT+2 .. 2*MEM_LAT+3 cycles; stalls in IDLE while UartOver is low.
module multi_cycle_seq
  import cpu_seq_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                MEM_LAT = 2,
  parameter int                CNT_W   = 32,
  parameter logic [DATA_W-1:0] BOOT_PC = '0
) (
  input logic              clk,
  input logic              reset,
  multi_cycle_seq_if.slave bus
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               ill_q, ill_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic               wait_load, wait_done, end_instr;
  op_class_e          cls;

  // Classification reads only the registered instruction, keeping MemInstr off the strobe paths.
  assign cls = classify(instr_q[OPC_W-1:0]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    ill_d     = ill_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    end_instr = 1'b0;

    case (state_q)
      S_IDLE:      if (bus.UartOver) state_d = S_FETCH;
      S_FETCH:     if (wait_done) begin
                     instr_d = bus.MemInstr;
                     state_d = S_DECODE;
                   end
      S_DECODE:    if (cls == CLS_ILLEGAL) begin
                     state_d = S_TRAP;
                     ill_d   = 1'b1;
                   end else begin
                     state_d = S_EXECUTE;
                   end
      S_EXECUTE:   case (cls)
                     CLS_LOAD, CLS_STORE: state_d   = S_MEMORY;
                     CLS_BRANCH:          end_instr = 1'b1;
                     default:             state_d   = S_WRITEBACK;
                   endcase
      S_MEMORY:    if (wait_done) begin
                     if (cls == CLS_LOAD) state_d   = S_WRITEBACK;
                     else                 end_instr = 1'b1;
                   end
      S_WRITEBACK: end_instr = 1'b1;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase

    // Retirement only on a real hand-off to the next fetch; a drop to IDLE leaves PC and count alone.
    if (end_instr) begin
      if (bus.UartOver) begin
        state_d = S_FETCH;
        pc_d    = bus.NextPc;
        ret_d   = ret_q + CNT_W'(1);
      end else begin
        state_d = S_IDLE;
      end
    end

    if (state_q != S_IDLE && state_q != S_TRAP)
      cyc_d = cyc_q + CNT_W'(1);
  end

  assign wait_load = (state_d != state_q) &&
                     (state_d == S_FETCH || state_d == S_MEMORY);

  wait_timer #(.MEM_LAT(MEM_LAT)) u_wait_timer (
    .clk   (clk),
    .rst_n (reset),
    .load  (wait_load),
    .done  (wait_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= BOOT_PC;
      instr_q <= '0;
      ill_q   <= 1'b0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ill_q   <= ill_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.PcOut        = pc_q;
  assign bus.InstrOut     = instr_q;
  assign bus.State        = state_q;
  assign bus.IllegalInstr = ill_q;
  assign bus.CycleCnt     = cyc_q;
  assign bus.RetireCnt    = ret_q;
  assign bus.MemReadEn    = (state_q == S_MEMORY) && (cls == CLS_LOAD);
  assign bus.MemWriteEn   = (state_q == S_MEMORY) && (cls == CLS_STORE);
  assign bus.RegWriteEn   = (state_q == S_WRITEBACK);
endmodule

// File: tb/tb_multi_cycle_seq.sv
// Randomized scoreboard bench for multi_cycle_seq with MEM_LAT=3 and 4-bit counters.
module tb_multi_cycle_seq;
  import cpu_seq_pkg::*;

  localparam int          DW = 32;
  localparam int          ML = 3;
  localparam int          CW = 4;
  localparam logic [31:0] BP = 32'h0000_0100;

  localparam logic [31:0] I_ADD = 32'h0031_00B3;
  localparam logic [31:0] I_LW  = 32'h0000_A103;
  localparam logic [31:0] I_SW  = 32'h0020_A023;
  localparam logic [31:0] I_BEQ = 32'h0020_8463;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          ret;
    int          cyc;
    int          lat;
    int          rw;
    int          mr;
    int          mw;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_cycle_seq_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  multi_cycle_seq #(.DATA_W(DW), .MEM_LAT(ML), .CNT_W(CW), .BOOT_PC(BP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   errs = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  int   m_ret, m_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: instruction kind from the opcode table; -1 means illegal.
  function automatic int kind_of(input logic [6:0] opc);
    case (opc)
      7'b0000011: return 1;
      7'b0100011: return 2;
      7'b1100011: return 3;
      7'b1101111, 7'b1100111, 7'b0110011,
      7'b0010011, 7'b0110111, 7'b0010111: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int lat_of(input int kind);
    case (kind)
      1:       return 2 * ML + 3;
      2:       return 2 * ML + 2;
      3:       return ML + 2;
      default: return ML + 3;
    endcase
  endfunction

  task automatic do_reset();
    mon_en       = 1'b0;
    reset        = 1'b0;
    bus.UartOver = 1'b0;
    bus.MemInstr = '0;
    bus.NextPc   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_ret = 0;
    m_cyc = 0;
    sb.delete();
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] np, input bit first);
    exp_t e;
    int   k;
    k = kind_of(ins[6:0]);
    bus.MemInstr = ins;
    bus.NextPc   = np;
    if (first) @(posedge clk);
    m_ret   = (m_ret + 1) % (1 << CW);
    m_cyc   = (m_cyc + lat_of(k)) % (1 << CW);
    e.pc    = np;
    e.instr = ins;
    e.ret   = m_ret;
    e.cyc   = m_cyc;
    e.lat   = lat_of(k);
    e.rw    = (k == 0 || k == 1) ? 1 : 0;
    e.mr    = (k == 1) ? ML : 0;
    e.mw    = (k == 2) ? ML : 0;
    sb.push_back(e);
    repeat (lat_of(k)) @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: a RetireCnt change marks the end of an instruction.
  initial begin : monitor
    logic [CW-1:0] prev_ret;
    int   n_cyc, n_rw, n_mr, n_mw;
    exp_t e;
    prev_ret = '0;
    n_cyc = 0; n_rw = 0; n_mr = 0; n_mw = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        n_cyc = 0; n_rw = 0; n_mr = 0; n_mw = 0;
      end else begin
        if (bus.RetireCnt !== prev_ret) begin
          if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_retire: got RetireCnt %0h with empty scoreboard", bus.RetireCnt);
          end else begin
            e = sb.pop_front();
            chk("retire_pc",    bus.PcOut,     e.pc);
            chk("retire_count", bus.RetireCnt, e.ret);
            chk("retire_instr", bus.InstrOut,  e.instr);
            chk("retire_cycle", bus.CycleCnt,  e.cyc);
            chk("latency",      n_cyc,         e.lat);
            chk("regwr_cycles", n_rw,          e.rw);
            chk("memrd_cycles", n_mr,          e.mr);
            chk("memwr_cycles", n_mw,          e.mw);
          end
          n_cyc = 0; n_rw = 0; n_mr = 0; n_mw = 0;
        end
        if (bus.State != S_IDLE && bus.State != S_TRAP) n_cyc++;
        n_rw += int'(bus.RegWriteEn);
        n_mr += int'(bus.MemReadEn);
        n_mw += int'(bus.MemWriteEn);
      end
      prev_ret = bus.RetireCnt;
    end
  end

  initial begin : stim
    logic [31:0] r, ins, np, last_cyc;
    int          k;

    do_reset();
    chk("rst_state",   bus.State,        S_IDLE);
    chk("rst_pc",      bus.PcOut,        BP);
    chk("rst_instr",   bus.InstrOut,     0);
    chk("rst_strobes", {bus.MemReadEn, bus.MemWriteEn, bus.RegWriteEn}, 0);
    chk("rst_illegal", bus.IllegalInstr, 0);
    chk("rst_cyc",     bus.CycleCnt,     0);
    chk("rst_ret",     bus.RetireCnt,    0);
    repeat (3) @(negedge clk);
    chk("idle_hold",   bus.State,        S_IDLE);
    chk("idle_cyc",    bus.CycleCnt,     0);

    // Directed opening, then a random legal mix long enough to wrap both counters.
    mon_en       = 1'b1;
    bus.UartOver = 1'b1;
    run_instr(I_ADD, 32'h0000_0104, 1'b1);
    run_instr(I_LW,  32'h0000_0108, 1'b0);
    run_instr(I_SW,  32'h0000_010C, 1'b0);
    run_instr(I_BEQ, 32'h0000_0040, 1'b0);
    for (int i = 0; i < 36; i++) begin
      do begin
        r   = $urandom;
        np  = $urandom;
        ins = {r[31:7], 7'(r[6:0])};
        k   = kind_of(ins[6:0]);
      end while (k < 0);
      run_instr(ins, np, 1'b0);
    end
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    // Illegal instruction: trap after DECODE, counters freeze.
    mon_en       = 1'b0;
    bus.MemInstr = 32'hFFFF_FFFF;
    repeat (ML + 1) @(posedge clk);
    @(negedge clk);
    last_cyc = 32'((m_cyc + ML + 1) % (1 << CW));
    chk("trap_state",   bus.State,        S_TRAP);
    chk("trap_illegal", bus.IllegalInstr, 1);
    chk("trap_cyc",     bus.CycleCnt,     last_cyc);
    repeat (6) @(negedge clk);
    chk("trap_hold",    bus.State,        S_TRAP);
    chk("trap_frozen",  bus.CycleCnt,     last_cyc);
    chk("trap_sticky",  bus.IllegalInstr, 1);
    chk("trap_strobes", {bus.MemReadEn, bus.MemWriteEn, bus.RegWriteEn}, 0);

    // Asynchronous reset in the middle of a load's memory phase.
    do_reset();
    chk("rst_clears_illegal", bus.IllegalInstr, 0);
    bus.UartOver = 1'b1;
    bus.MemInstr = I_LW;
    bus.NextPc   = 32'h0000_0500;
    @(posedge clk);
    repeat (ML + 3) @(posedge clk);
    @(negedge clk);
    chk("lw_in_memory", bus.State,     S_MEMORY);
    chk("lw_memrd",     bus.MemReadEn, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", bus.State,     S_IDLE);
    chk("async_rst_pc",    bus.PcOut,     BP);
    chk("async_rst_memrd", bus.MemReadEn, 0);
    chk("async_rst_cyc",   bus.CycleCnt,  0);
    chk("async_rst_instr", bus.InstrOut,  0);

    // UartOver falls during WRITEBACK: finish the instruction, return to IDLE, keep the PC.
    do_reset();
    bus.UartOver = 1'b1;
    bus.MemInstr = I_ADD;
    bus.NextPc   = 32'h0000_0200;
    @(posedge clk);
    repeat (ML + 3) @(posedge clk);
    @(negedge clk);
    chk("drop_first_pc", bus.PcOut, 32'h0000_0200);
    bus.NextPc = 32'h0000_0300;
    repeat (ML + 2) @(posedge clk);
    @(negedge clk);
    chk("drop_in_wb",    bus.State,      S_WRITEBACK);
    chk("drop_wb_regwr", bus.RegWriteEn, 1);
    bus.UartOver = 1'b0;
    @(negedge clk);
    chk("drop_idle",     bus.State,      S_IDLE);
    chk("drop_pc_kept",  bus.PcOut,      32'h0000_0200);
    chk("drop_regwr",    bus.RegWriteEn, 0);
    repeat (3) @(negedge clk);
    chk("drop_idle_hold", bus.State,     S_IDLE);
    bus.UartOver = 1'b1;
    @(negedge clk);
    chk("restart_fetch", bus.State,      S_FETCH);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
